// File: rtl/bsg_manycore_tile_mem_arb_pkg.sv
// Shared types and sizing helpers for the tile data-memory arbiter.
// Holds the lock state encoding and the starvation counter width rule.
package bsg_manycore_tile_mem_arb_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Counter must be able to hold the limit value itself.
    function automatic int starve_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bsg_manycore_tile_mem_arb_if.sv
// Packet, core-request and memory-bus signal bundle of the tile memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding tile's view.
interface bsg_manycore_tile_mem_arb_if #(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 12
) ();
    localparam int mask_width_lp = data_width_p / 8;

    logic                      pkt_v_i;
    logic                      pkt_remote_store_i;
    logic                      pkt_freeze_i;
    logic                      pkt_unfreeze_i;
    logic                      pkt_unknown_i;
    logic                      pkt_lock_req_i;
    logic [data_width_p-1:0]   pkt_data_i;
    logic [addr_width_p-1:0]   pkt_addr_i;
    logic [mask_width_lp-1:0]  pkt_mask_i;
    logic [x_cord_width_p-1:0] pkt_from_x_i;
    logic [y_cord_width_p-1:0] pkt_from_y_i;
    logic                      pkt_yumi_o;

    logic                      core_v_i;
    logic                      core_w_i;
    logic [addr_width_p-1:0]   core_addr_i;
    logic [data_width_p-1:0]   core_data_i;
    logic [mask_width_lp-1:0]  core_mask_i;
    logic                      core_yumi_o;

    logic                      mem_v_o;
    logic                      mem_w_o;
    logic [addr_width_p-1:0]   mem_addr_o;
    logic [data_width_p-1:0]   mem_data_o;
    logic [mask_width_lp-1:0]  mem_mask_o;

    modport slave (
        input  pkt_v_i, pkt_remote_store_i, pkt_freeze_i, pkt_unfreeze_i,
               pkt_unknown_i, pkt_lock_req_i, pkt_data_i, pkt_addr_i,
               pkt_mask_i, pkt_from_x_i, pkt_from_y_i,
               core_v_i, core_w_i, core_addr_i, core_data_i, core_mask_i,
        output pkt_yumi_o, core_yumi_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o
    );

    modport master (
        output pkt_v_i, pkt_remote_store_i, pkt_freeze_i, pkt_unfreeze_i,
               pkt_unknown_i, pkt_lock_req_i, pkt_data_i, pkt_addr_i,
               pkt_mask_i, pkt_from_x_i, pkt_from_y_i,
               core_v_i, core_w_i, core_addr_i, core_data_i, core_mask_i,
        input  pkt_yumi_o, core_yumi_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o
    );
endinterface

// File: rtl/bsg_manycore_lock_ctrl.sv
// Tile lock FSM: tracks UNLOCKED/LOCKED plus owner coordinates and decides
// which acquire packets and remote stores must stall.
module bsg_manycore_lock_ctrl
    import bsg_manycore_tile_mem_arb_pkg::*;
#(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      lock_evt_i,
    input  logic                      acquire_i,
    input  logic [x_cord_width_p-1:0] from_x_i,
    input  logic [y_cord_width_p-1:0] from_y_i,
    output logic                      acquire_stall_o,
    output logic                      store_block_o,
    output logic                      lock_held_o,
    output logic [x_cord_width_p-1:0] owner_x_o,
    output logic [y_cord_width_p-1:0] owner_y_o
);
    lock_state_e               state_r, state_next_s;
    logic [x_cord_width_p-1:0] owner_x_r, owner_x_next_s;
    logic [y_cord_width_p-1:0] owner_y_r, owner_y_next_s;
    logic                      from_owner_s;

    assign from_owner_s = (from_x_i == owner_x_r) && (from_y_i == owner_y_r);

    // State and owner registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= UNLOCKED;
            owner_x_r <= '0;
            owner_y_r <= '0;
        end else begin
            state_r   <= state_next_s;
            owner_x_r <= owner_x_next_s;
            owner_y_r <= owner_y_next_s;
        end
    end

    // Next-state, owner capture and stall decisions.
    always_comb begin
        state_next_s    = state_r;
        owner_x_next_s  = owner_x_r;
        owner_y_next_s  = owner_y_r;
        acquire_stall_o = 1'b0;
        store_block_o   = 1'b0;
        case (state_r)
            UNLOCKED: begin
                if (lock_evt_i && acquire_i) begin
                    state_next_s   = LOCKED;
                    owner_x_next_s = from_x_i;
                    owner_y_next_s = from_y_i;
                end else begin
                    state_next_s   = UNLOCKED;
                end
            end
            LOCKED: begin
                store_block_o = !from_owner_s;
                if (lock_evt_i && acquire_i && !from_owner_s) begin
                    acquire_stall_o = 1'b1;
                end else if (lock_evt_i && !acquire_i && from_owner_s) begin
                    state_next_s = UNLOCKED;
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: begin
                state_next_s = UNLOCKED;
            end
        endcase
    end

    assign lock_held_o = (state_r == LOCKED);
    assign owner_x_o   = owner_x_r;
    assign owner_y_o   = owner_y_r;

endmodule

// File: rtl/bsg_manycore_tile_mem_arb.sv
// Tile data-memory arbiter: shares the single-port memory between remote stores
// and the core, applies freeze/lock/unknown packet actions, guards core starvation.
module bsg_manycore_tile_mem_arb
    import bsg_manycore_tile_mem_arb_pkg::*;
#(
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 12,
    parameter int starve_limit_p = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    bsg_manycore_tile_mem_arb_if.slave  bus,
    output logic                        remote_store_done_o,
    output logic                        freeze_o,
    output logic                        lock_held_o,
    output logic [x_cord_width_p-1:0]   lock_owner_x_o,
    output logic [y_cord_width_p-1:0]   lock_owner_y_o,
    output logic                        unknown_pkt_o
);
    localparam int cnt_width_lp = starve_cnt_width(starve_limit_p);
    localparam logic [cnt_width_lp-1:0] starve_limit_lp = cnt_width_lp'(starve_limit_p);

    logic                    pkt_v_s;
    logic                    lock_evt_s;
    logic                    acquire_stall_s;
    logic                    store_block_s;
    logic                    remote_elig_s;
    logic                    core_elig_s;
    logic                    core_win_s;
    logic                    remote_win_s;
    logic                    ctrl_take_s;
    logic                    freeze_r;
    logic                    done_r;
    logic                    unknown_r;
    logic [cnt_width_lp-1:0] cnt_r, cnt_next_s;

    // Grants are suppressed while reset is held so nothing is consumed mid-reset.
    assign pkt_v_s    = bus.pkt_v_i && reset_n_i;
    assign lock_evt_s = pkt_v_s && bus.pkt_lock_req_i;

    bsg_manycore_lock_ctrl #(
        .x_cord_width_p (x_cord_width_p),
        .y_cord_width_p (y_cord_width_p)
    ) lock_ctrl (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .lock_evt_i      (lock_evt_s),
        .acquire_i       (bus.pkt_data_i[0]),
        .from_x_i        (bus.pkt_from_x_i),
        .from_y_i        (bus.pkt_from_y_i),
        .acquire_stall_o (acquire_stall_s),
        .store_block_o   (store_block_s),
        .lock_held_o     (lock_held_o),
        .owner_x_o       (lock_owner_x_o),
        .owner_y_o       (lock_owner_y_o)
    );

    assign remote_elig_s = pkt_v_s && bus.pkt_remote_store_i && !store_block_s;
    assign core_elig_s   = bus.core_v_i && reset_n_i && !freeze_r;
    assign core_win_s    = core_elig_s && (!remote_elig_s || (cnt_r == starve_limit_lp));
    assign remote_win_s  = remote_elig_s && !core_win_s;

    // Control packets never need the memory; only a blocked acquire waits.
    assign ctrl_take_s = pkt_v_s && (bus.pkt_freeze_i || bus.pkt_unfreeze_i ||
                                     bus.pkt_unknown_i ||
                                     (bus.pkt_lock_req_i && !acquire_stall_s));

    assign bus.pkt_yumi_o  = remote_win_s || ctrl_take_s;
    assign bus.core_yumi_o = core_win_s;

    // Memory bus driven from whichever side won this cycle.
    always_comb begin
        bus.mem_v_o    = 1'b0;
        bus.mem_w_o    = 1'b0;
        bus.mem_addr_o = '0;
        bus.mem_data_o = '0;
        bus.mem_mask_o = '0;
        if (remote_win_s) begin
            bus.mem_v_o    = 1'b1;
            bus.mem_w_o    = 1'b1;
            bus.mem_addr_o = bus.pkt_addr_i;
            bus.mem_data_o = bus.pkt_data_i;
            bus.mem_mask_o = bus.pkt_mask_i;
        end else if (core_win_s) begin
            bus.mem_v_o    = 1'b1;
            bus.mem_w_o    = bus.core_w_i;
            bus.mem_addr_o = bus.core_addr_i;
            bus.mem_data_o = bus.core_data_i;
            bus.mem_mask_o = bus.core_mask_i;
        end else begin
            bus.mem_v_o    = 1'b0;
        end
    end

    // Starvation counter: counts core cycles lost to remote stores.
    always_comb begin
        cnt_next_s = cnt_r;
        if (freeze_r) begin
            cnt_next_s = cnt_r;
        end else if (!bus.core_v_i || core_win_s) begin
            cnt_next_s = '0;
        end else if (remote_win_s) begin
            cnt_next_s = cnt_r + cnt_width_lp'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Freeze, pulse and counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            freeze_r  <= 1'b1;
            done_r    <= 1'b0;
            unknown_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            if (pkt_v_s && bus.pkt_freeze_i) begin
                freeze_r <= 1'b1;
            end else if (pkt_v_s && bus.pkt_unfreeze_i) begin
                freeze_r <= 1'b0;
            end else begin
                freeze_r <= freeze_r;
            end
            done_r    <= remote_win_s;
            unknown_r <= pkt_v_s && bus.pkt_unknown_i;
            cnt_r     <= cnt_next_s;
        end
    end

    assign freeze_o            = freeze_r;
    assign remote_store_done_o = done_r;
    assign unknown_pkt_o       = unknown_r;

endmodule

// File: tb/tb_bsg_manycore_tile_mem_arb.sv
// Scoreboard bench for the tile memory arbiter: a behavioural model predicts each
// cycle's outputs into a queue, and a negedge monitor compares the DUT against it.
module tb_bsg_manycore_tile_mem_arb;
    localparam int XW = 4, YW = 4, DW = 32, AW = 12, MW = DW / 8, LIM = 4;

    typedef struct {
        logic          pkt_yumi, core_yumi, mem_v, mem_w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic          frz, held, done, unk;
        logic [XW-1:0] ox;
        logic [YW-1:0] oy;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          freeze, lock_held, done, unk;
    logic [XW-1:0] own_x;
    logic [YW-1:0] own_y;

    exp_t sb_q[$];
    int   checks = 0, errors = 0, core_seen = 0;

    // behavioural state of the tile as seen from outside
    bit            m_frozen, m_locked, m_done, m_unk;
    logic [XW-1:0] m_ox;
    logic [YW-1:0] m_oy;
    int            m_lost;

    always #5 clk = ~clk;

    bsg_manycore_tile_mem_arb_if #(
        .x_cord_width_p(XW), .y_cord_width_p(YW),
        .data_width_p(DW), .addr_width_p(AW)
    ) bus ();

    bsg_manycore_tile_mem_arb #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .starve_limit_p(LIM)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .bus(bus.slave),
        .remote_store_done_o(done), .freeze_o(freeze), .lock_held_o(lock_held),
        .lock_owner_x_o(own_x), .lock_owner_y_o(own_y), .unknown_pkt_o(unk)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // cls: 0 none, 1 store, 2 freeze, 3 unfreeze, 4 unknown, 5 lock
    task automatic set_pkt(input int cls, input logic [XW-1:0] fx, input logic [YW-1:0] fy,
                           input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [MW-1:0] m);
        bus.pkt_v_i            = (cls != 0);
        bus.pkt_remote_store_i = (cls == 1);
        bus.pkt_freeze_i       = (cls == 2);
        bus.pkt_unfreeze_i     = (cls == 3);
        bus.pkt_unknown_i      = (cls == 4);
        bus.pkt_lock_req_i     = (cls == 5);
        bus.pkt_from_x_i = fx; bus.pkt_from_y_i = fy;
        bus.pkt_data_i = d; bus.pkt_addr_i = a; bus.pkt_mask_i = m;
    endtask

    task automatic set_core(input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [MW-1:0] m);
        bus.core_v_i = v; bus.core_w_i = w; bus.core_addr_i = a;
        bus.core_data_i = d; bus.core_mask_i = m;
    endtask

    task automatic idle();
        set_pkt(0, '0, '0, '0, '0, '0);
        set_core(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Predict this cycle from the model, queue it, then advance the model one edge.
    task automatic step();
        exp_t e;
        bit pv, sender_is_owner, stalled, store_ok, core_ok, core_gets, store_gets;
        e = '{default: '0};
        if (!reset_n) begin
            e.frz = 1'b1;
            sb_q.push_back(e);
            m_frozen = 1'b1; m_locked = 1'b0; m_ox = '0; m_oy = '0;
            m_lost = 0; m_done = 1'b0; m_unk = 1'b0;
        end else begin
            pv = bus.pkt_v_i;
            sender_is_owner = (bus.pkt_from_x_i == m_ox) && (bus.pkt_from_y_i == m_oy);
            stalled   = pv && bus.pkt_lock_req_i && bus.pkt_data_i[0] && m_locked && !sender_is_owner;
            store_ok  = pv && bus.pkt_remote_store_i && !(m_locked && !sender_is_owner);
            core_ok   = bus.core_v_i && !m_frozen;
            core_gets = core_ok && (!store_ok || m_lost == LIM);
            store_gets = store_ok && !core_gets;
            e.pkt_yumi  = store_gets || (pv && (bus.pkt_freeze_i || bus.pkt_unfreeze_i ||
                          bus.pkt_unknown_i)) || (pv && bus.pkt_lock_req_i && !stalled);
            e.core_yumi = core_gets;
            e.mem_v     = store_gets || core_gets;
            e.mem_w     = store_gets ? 1'b1 : bus.core_w_i;
            e.addr      = store_gets ? bus.pkt_addr_i : bus.core_addr_i;
            e.data      = store_gets ? bus.pkt_data_i : bus.core_data_i;
            e.mask      = store_gets ? bus.pkt_mask_i : bus.core_mask_i;
            e.frz = m_frozen; e.held = m_locked; e.ox = m_ox; e.oy = m_oy;
            e.done = m_done; e.unk = m_unk;
            sb_q.push_back(e);
            if (!m_frozen) begin
                if (!bus.core_v_i || core_gets) m_lost = 0;
                else if (store_gets)             m_lost = m_lost + 1;
            end
            if (pv && bus.pkt_freeze_i)   m_frozen = 1'b1;
            if (pv && bus.pkt_unfreeze_i) m_frozen = 1'b0;
            if (pv && bus.pkt_lock_req_i) begin
                if (bus.pkt_data_i[0] && !m_locked) begin
                    m_locked = 1'b1; m_ox = bus.pkt_from_x_i; m_oy = bus.pkt_from_y_i;
                end else if (!bus.pkt_data_i[0] && m_locked && sender_is_owner) begin
                    m_locked = 1'b0;
                end
            end
            m_done = store_gets;
            m_unk  = pv && bus.pkt_unknown_i;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every cycle's outputs against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pkt_yumi", 64'(bus.pkt_yumi_o), 64'(e.pkt_yumi));
            chk("core_yumi", 64'(bus.core_yumi_o), 64'(e.core_yumi));
            chk("mem_v", 64'(bus.mem_v_o), 64'(e.mem_v));
            if (e.mem_v) begin
                chk("mem_w", 64'(bus.mem_w_o), 64'(e.mem_w));
                chk("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
                chk("mem_data", 64'(bus.mem_data_o), 64'(e.data));
                chk("mem_mask", 64'(bus.mem_mask_o), 64'(e.mask));
            end
            chk("freeze", 64'(freeze), 64'(e.frz));
            chk("lock_held", 64'(lock_held), 64'(e.held));
            chk("owner_x", 64'(own_x), 64'(e.ox));
            chk("owner_y", 64'(own_y), 64'(e.oy));
            chk("store_done", 64'(done), 64'(e.done));
            chk("unknown_pkt", 64'(unk), 64'(e.unk));
            if (bus.core_yumi_o === 1'b1) core_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        logic [XW-1:0] cx[3];
        logic [YW-1:0] cy[3];
        cx[0] = 4'd1; cy[0] = 4'd2;
        cx[1] = 4'd3; cy[1] = 4'd0;
        cx[2] = 4'd0; cy[2] = 4'd0;

        reset_n = 1'b0;
        idle();
        @(posedge clk); #1;
        step(); step();
        reset_n = 1'b1;
        step();

        // remote store while frozen; the core request must not be granted
        set_pkt(1, 4'd0, 4'd0, 32'hDEADBEEF, 12'h010, 4'hF);
        set_core(1'b1, 1'b0, 12'h020, 32'h0, 4'hF);
        step();
        set_pkt(0, '0, '0, '0, '0, '0);
        step();

        // unfreeze in cycle N, core wins in N+1
        set_pkt(3, '0, '0, '0, '0, '0);
        step();
        set_pkt(0, '0, '0, '0, '0, '0);
        step();
        idle(); step();

        // continuous contention: 4 remote grants then 1 core grant, twice
        base = core_seen;
        for (int i = 0; i < 10; i++) begin
            set_pkt(1, 4'd0, 4'd0, $urandom, AW'(i), 4'hF);
            set_core(1'b1, 1'b0, 12'h100, 32'h0, 4'hF);
            step();
        end
        chk("starve_core_grants", 64'(core_seen - base), 64'd2);
        idle(); step();

        // lock acquired by (1,2) blocks (3,0) stores until release
        set_pkt(5, 4'd1, 4'd2, 32'h1, '0, '0);          step();
        set_pkt(1, 4'd3, 4'd0, 32'hA5A5A5A5, 12'h044, 4'h3); step();
        set_pkt(1, 4'd1, 4'd2, 32'h12345678, 12'h048, 4'hF); step();
        set_pkt(5, 4'd1, 4'd2, 32'h0, '0, '0);          step();
        set_pkt(1, 4'd3, 4'd0, 32'hA5A5A5A5, 12'h044, 4'h3); step();

        // competing acquire stalls until the owner releases
        set_pkt(5, 4'd1, 4'd2, 32'h1, '0, '0); step();
        set_pkt(5, 4'd3, 4'd0, 32'h1, '0, '0); step(); step();
        set_pkt(5, 4'd1, 4'd2, 32'h0, '0, '0); step();
        set_pkt(5, 4'd3, 4'd0, 32'h1, '0, '0); step();
        set_pkt(5, 4'd3, 4'd0, 32'h0, '0, '0); step();

        // unknown packet pulses once
        set_pkt(4, '0, '0, '0, '0, '0); step();
        idle(); step(); step();

        // reset during a stalled acquire
        set_pkt(5, 4'd1, 4'd2, 32'h1, '0, '0); step();
        set_pkt(5, 4'd3, 4'd0, 32'h1, '0, '0); step();
        reset_n = 1'b0; step(); step();
        idle(); reset_n = 1'b1; step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int cls, k;
            k = $urandom_range(0, 2);
            cls = $urandom_range(0, 9);
            if (cls >= 6) cls = 1;
            if (cls == 2 && $urandom_range(0, 3) != 0) cls = 3;
            set_pkt(cls, cx[k], cy[k], $urandom, AW'($urandom), MW'($urandom));
            set_core(1'($urandom), 1'($urandom), AW'($urandom), $urandom, MW'($urandom));
            step();
        end
        idle(); step(); step();

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bsg_manycore_tile_mem_arb.md
# bsg_manycore_tile_mem_arb

Arbitration and sequencing controller for a tile's single-port data memory. It sits between the decoded incoming-network packet path and the local core. It shares the memory between remote stores and core accesses, and applies the packet-driven control actions: freeze/unfreeze, lock acquire/release, and discard of unknown packets. It also keeps the tile's freeze and lock state.

## Interface
Parameters:
- x_cord_width_p, "inv": X coordinate width
- y_cord_width_p, "inv": Y coordinate width
- data_width_p, "inv": data word width (multiple of 8)
- addr_width_p, "inv": word address width
- starve_limit_p, 4: consecutive lost core cycles before the core is forced a grant (≥1)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- pkt_v_i  in  1  decoded packet valid (head of network input FIFO)
- pkt_remote_store_i, pkt_freeze_i, pkt_unfreeze_i, pkt_unknown_i, pkt_lock_req_i  in  1 each  decoded class; one-hot when pkt_v_i
- pkt_data_i  in  data_width_p  packet data; bit 0 = acquire(1)/release(0) for lock requests
- pkt_addr_i  in  addr_width_p  store address
- pkt_mask_i  in  data_width_p/8  byte mask
- pkt_from_x_i / pkt_from_y_i  in  x/y_cord_width_p  sender coordinates
- pkt_yumi_o  out  1  packet consumed this cycle
- core_v_i, core_w_i  in  1  core request valid, write
- core_addr_i  in  addr_width_p; core_data_i  in  data_width_p; core_mask_i  in  data_width_p/8
- core_yumi_o  out  1  core request granted this cycle
- mem_v_o, mem_w_o  out  1; mem_addr_o  out  addr_width_p; mem_data_o  out  data_width_p; mem_mask_o  out  data_width_p/8
- remote_store_done_o  out  1  pulse one cycle after a remote store is written
- freeze_o  out  1  tile frozen
- lock_held_o  out  1; lock_owner_x_o / lock_owner_y_o  out  x/y_cord_width_p
- unknown_pkt_o  out  1  pulse one cycle after an unknown packet is discarded

## Operation
- Reset values: freeze_o=1, lock_held_o=0, owner=0, starvation counter=0, remote_store_done_o=0, unknown_pkt_o=0. Combinational outputs are 0 while inputs are idle.
- Lock FSM, UNLOCKED/LOCKED:
  - Acquire in UNLOCKED: consume, go to LOCKED, record owner.
  - Acquire in LOCKED from the owner: consume, no change.
  - Acquire in LOCKED from another tile: stall, no yumi.
  - Release from the owner: consume, go to UNLOCKED.
  - Release from a non-owner, or in UNLOCKED: consume, no change.
- Remote store: needs the memory grant. Stalls while LOCKED and the sender is not the owner.
- Freeze/unfreeze: consumed without the memory. freeze_o set/cleared next cycle.
- Unknown: consumed immediately, then unknown_pkt_o pulses.
- Freeze and lock packets are always consumed in their arrival cycle unless they are stalled acquires. They never conflict with the core.
- Core: blocked while freeze_o=1. Freeze does not block remote stores, which is how the program is loaded.
- Arbitration, when an eligible remote store and an eligible core request coexist:
  - Remote wins, and the starvation counter increments.
  - When the counter equals starve_limit_p, the core wins and the counter clears.
  - The counter clears on any core grant and whenever the core is not requesting.
  - The counter holds while the core is frozen.
- The memory bus is driven from the winner. mem_v_o equals (pkt_yumi_o for a store) or core_yumi_o. mem_w_o is 1 for remote stores.

## Timing
- Grants are combinational in the request cycle: yumi and mem_* are asserted in the same cycle. The memory is single-cycle.
- remote_store_done_o, unknown_pkt_o, freeze_o and lock updates take effect on the next rising edge.
- An unfreeze consumed in cycle N lets a core request win in cycle N+1 at the earliest.
- A lock acquired in cycle N blocks other senders' stores from cycle N+1.
- Reset assertion mid-operation clears all state immediately. The result is frozen and unlocked, and pending pulses are dropped.
- pkt_v_i=0 leaves all packet-class inputs ignored.

## Structure
- A shared package holds the lock state enum, typedef lock_state_e {UNLOCKED, LOCKED}, and the starvation counter width, $clog2(starve_limit_p+1).
- One natural sub-module, bsg_manycore_lock_ctrl, holds the lock FSM, owner registers and stall decision. The arbiter, freeze register and pulse registers stay in the top.

## Test plan
- Out of reset, one remote store to addr 0x10 with data 0xDEADBEEF, mask 0xF → same-cycle pkt_yumi_o and mem_w_o. remote_store_done_o=1 next cycle. freeze_o stays 1, and core_v_i is not granted.
- Unfreeze packet, then core read at the next cycle → core_yumi_o=1 in cycle N+1, freeze_o=0.
- Continuous remote stores plus continuous core reads with starve_limit_p=4 → four remote grants, then one core grant, repeating.
- Lock acquire from (1,2), then store from (3,0) → store stalled with no yumi. Store from (1,2) is granted. After release from (1,2), the (3,0) store is granted next cycle.
- Acquire from (3,0) while locked by (1,2) → stalled until the release. Owner then becomes (3,0).
- Unknown packet → consumed the same cycle, unknown_pkt_o pulses once. Asserting reset_n_i low during a stalled lock acquire → unlocked and frozen, with no yumi.
